// File: rtl/eth_ts_pkg.sv
// Shared definitions for the timestamped test-frame sender.
//   state_t      : sender FSM states
//   axis_beat_t  : one formatted AXI4-Stream beat (data, keep, last)
//   clamp_len    : limits a requested frame length to the legal Ethernet range
package eth_ts_pkg;

    localparam int unsigned LEN_W  = 11;
    localparam int unsigned BEAT_W = 8;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned HDR_W  = 256;

    localparam logic [15:0]      ETHERTYPE = 16'h88B5;
    localparam logic [LEN_W-1:0] MIN_LEN   = 11'd60;
    localparam logic [LEN_W-1:0] MAX_LEN   = 11'd1514;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
    } axis_beat_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len < MIN_LEN)      return MIN_LEN;
        else if (len > MAX_LEN) return MAX_LEN;
        else                    return len;
    endfunction

endpackage

// File: rtl/eth_ts_beat_fmt.sv
// Combinational formatter: builds one 64-bit beat of the test frame.
//   beat            : beat index within the frame
//   len             : frame length in bytes (already clamped, 60..1514)
//   dst_mac/src_mac : header addresses
//   flow_id, seq    : flow number and its sequence value (seq zero-extended)
//   ts              : timestamp captured at frame start (zero-extended)
//   beat_c          : tdata/tkeep/tlast for this beat; bytes past len are zero
module eth_ts_beat_fmt
    import eth_ts_pkg::*;
(
    input  logic [BEAT_W-1:0] beat,
    input  logic [LEN_W-1:0]  len,
    input  logic [47:0]       dst_mac,
    input  logic [47:0]       src_mac,
    input  logic [7:0]        flow_id,
    input  logic [31:0]       seq,
    input  logic [63:0]       ts,
    output axis_beat_t        beat_c
);

    logic [HDR_W-1:0]  hdr;
    logic [BEAT_W-1:0] last_beat;
    logic [LEN_W-1:0]  n;

    // 32-byte header, byte 0 in the most significant position
    assign hdr = {dst_mac, src_mac, ETHERTYPE, flow_id, 8'h00, seq, 32'h0, ts};

    // len is never below 60, so len-1 cannot underflow
    assign last_beat = BEAT_W'((len - LEN_W'(1)) >> 3);

    // Byte lane i carries frame byte n = 8*beat + i
    always_comb begin
        beat_c = '0;
        n      = '0;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            n = {beat, 3'(i)};
            if (n < len) begin
                if (n < LEN_W'(32)) beat_c.tdata[8*i +: 8] = hdr[8*(31 - int'(n[4:0])) +: 8];
                else                beat_c.tdata[8*i +: 8] = n[7:0];
            end
        end
        beat_c.tlast = (beat == last_beat);
        beat_c.tkeep = '1;
        if (beat_c.tlast && (len[2:0] != 3'd0))
            beat_c.tkeep = KEEP_W'((9'd1 << len[2:0]) - 9'd1);
    end

endmodule

// File: rtl/eth_ts_send.sv
// Timestamped test-frame generator with round-robin flows.
//   clk156, s_aresetn   : clock, synchronous active-low reset
//   enable              : level; starts / continues generation
//   frame_len           : frame bytes without FCS (clamped 60..1514)
//   ifg_cycles          : idle cycles between frames (0 = back-to-back)
//   burst_count         : frames per run, 0 = continuous
//   dst_mac, src_mac    : header addresses
//   m_axis_*            : AXI4-Stream master, tuser tied low
//   busy, done          : sending/gap indicator, run-complete indicator
//   frames_sent         : total frames completed since reset (wraps)
module eth_ts_send
    import eth_ts_pkg::*;
#(
    parameter int unsigned FLOWS = 4,
    parameter int unsigned SEQ_W = 32,
    parameter int unsigned TS_W  = 64
) (
    input  logic        clk156,
    input  logic        s_aresetn,
    input  logic        enable,
    input  logic [10:0] frame_len,
    input  logic [7:0]  ifg_cycles,
    input  logic [15:0] burst_count,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy,
    output logic        done,
    output logic [31:0] frames_sent
);

    localparam int unsigned FLOW_W = (FLOWS > 1) ? $clog2(FLOWS) : 1;
    localparam int unsigned SLOTS  = 1 << FLOW_W;
    localparam logic [FLOW_W-1:0] LAST_FLOW = FLOW_W'(FLOWS - 1);

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        ifg_q, ifg_d;
    logic [7:0]        gap_q, gap_d;
    logic [15:0]       burst_q, burst_d;
    logic [15:0]       run_q, run_d;
    logic [47:0]       dst_q, dst_d;
    logic [47:0]       src_q, src_d;
    logic [FLOW_W-1:0] flow_q, flow_d;
    logic [SEQ_W-1:0]  seq_q [SLOTS];
    logic [SEQ_W-1:0]  seq_d [SLOTS];
    logic [TS_W-1:0]   ts_cnt_q;
    logic [TS_W-1:0]   ts_cap_q, ts_cap_d;
    logic [31:0]       frames_d;
    logic              frame_done;
    logic              tvalid_d;
    logic [SEQ_W-1:0]  seq_sel;
    axis_beat_t        fmt_c;

    assign m_axis_tuser = 1'b0;

    // Output beat is formatted from next-cycle values so it can be registered
    assign seq_sel = seq_d[flow_d];

    eth_ts_beat_fmt u_fmt (
        .beat    (beat_d),
        .len     (len_d),
        .dst_mac (dst_d),
        .src_mac (src_d),
        .flow_id (8'(flow_d)),
        .seq     (32'(seq_sel)),
        .ts      (64'(ts_cap_d)),
        .beat_c  (fmt_c)
    );

    // Next-state, per-flow counters and frame bookkeeping
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        len_d      = len_q;
        ifg_d      = ifg_q;
        gap_d      = gap_q;
        burst_d    = burst_q;
        run_d      = run_q;
        dst_d      = dst_q;
        src_d      = src_q;
        flow_d     = flow_q;
        seq_d      = seq_q;
        ts_cap_d   = ts_cap_q;
        frames_d   = frames_sent;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_SEND;
                    len_d    = clamp_len(frame_len);
                    ifg_d    = ifg_cycles;
                    burst_d  = burst_count;
                    dst_d    = dst_mac;
                    src_d    = src_mac;
                    run_d    = '0;
                    beat_d   = '0;
                    ts_cap_d = ts_cnt_q;
                end
            end
            ST_SEND: begin
                // tvalid is always high here, so tready alone means a handshake
                if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        frames_d      = frames_sent + 32'd1;
                        seq_d[flow_q] = seq_q[flow_q] + SEQ_W'(1);
                        flow_d        = (flow_q == LAST_FLOW) ? '0 : flow_q + FLOW_W'(1);
                        run_d         = run_q + 16'd1;
                        if (ifg_q != 8'd0) begin
                            state_d = ST_GAP;
                            gap_d   = ifg_q;
                        end else begin
                            frame_done = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd1) frame_done = 1'b1;
                else               gap_d = gap_q - 8'd1;
            end
            ST_DONE: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // End of frame plus gap: finish the run, stop, or start the next frame
        if (frame_done) begin
            if ((burst_q != 16'd0) && (run_d == burst_q)) begin
                state_d = ST_DONE;
            end else if (!enable) begin
                state_d = ST_IDLE;
            end else begin
                state_d  = ST_SEND;
                beat_d   = '0;
                ts_cap_d = ts_cnt_q;
            end
        end

        tvalid_d = (state_d == ST_SEND);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk156) begin
        if (!s_aresetn) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            len_q         <= '0;
            ifg_q         <= '0;
            gap_q         <= '0;
            burst_q       <= '0;
            run_q         <= '0;
            dst_q         <= '0;
            src_q         <= '0;
            flow_q        <= '0;
            seq_q         <= '{default: '0};
            ts_cnt_q      <= '0;
            ts_cap_q      <= '0;
            frames_sent   <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            len_q         <= len_d;
            ifg_q         <= ifg_d;
            gap_q         <= gap_d;
            burst_q       <= burst_d;
            run_q         <= run_d;
            dst_q         <= dst_d;
            src_q         <= src_d;
            flow_q        <= flow_d;
            seq_q         <= seq_d;
            ts_cnt_q      <= ts_cnt_q + TS_W'(1);
            ts_cap_q      <= ts_cap_d;
            frames_sent   <= frames_d;
            m_axis_tvalid <= tvalid_d;
            m_axis_tdata  <= tvalid_d ? fmt_c.tdata : '0;
            m_axis_tkeep  <= tvalid_d ? fmt_c.tkeep : '0;
            m_axis_tlast  <= tvalid_d & fmt_c.tlast;
            busy          <= (state_d == ST_SEND) || (state_d == ST_GAP);
            done          <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_eth_ts_send.sv
// Self-checking bench for eth_ts_send: directed scenarios plus randomized runs,
// every beat compared against a byte-level frame model.
module tb_eth_ts_send;

    localparam int FLOWS = 4;

    logic        clk156 = 1'b0;
    logic        s_aresetn;
    logic        enable;
    logic [10:0] frame_len;
    logic [7:0]  ifg_cycles;
    logic [15:0] burst_count;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;

    always #5 clk156 = ~clk156;

    eth_ts_send #(.FLOWS(FLOWS), .SEQ_W(32), .TS_W(64)) dut (
        .clk156        (clk156),
        .s_aresetn     (s_aresetn),
        .enable        (enable),
        .frame_len     (frame_len),
        .ifg_cycles    (ifg_cycles),
        .burst_count   (burst_count),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent)
    );

    int checks = 0;
    int errors = 0;

    // Reference time base: the free-running timestamp and a plain cycle count
    longint unsigned tb_ts = 0;
    int              cyc   = 0;
    always @(posedge clk156) begin
        cyc <= cyc + 1;
        if (!s_aresetn) tb_ts <= 0;
        else            tb_ts <= tb_ts + 1;
    end

    // Frame model state
    int          m_flow;
    int unsigned m_seq [16];
    int unsigned m_frames;
    logic [47:0] m_dst, m_src;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampl(input int l);
        if (l < 60)   return 60;
        if (l > 1514) return 1514;
        return l;
    endfunction

    function automatic logic [7:0] exp_byte(input int n, input int flow,
                                            input logic [31:0] seq, input logic [63:0] ts);
        if (n <= 5)  return m_dst[8*(5-n) +: 8];
        if (n <= 11) return m_src[8*(11-n) +: 8];
        if (n == 12) return 8'h88;
        if (n == 13) return 8'hB5;
        if (n == 14) return 8'(flow);
        if (n == 15) return 8'h00;
        if (n <= 19) return seq[8*(19-n) +: 8];
        if (n <= 23) return 8'h00;
        if (n <= 31) return ts[8*(31-n) +: 8];
        return 8'(n & 255);
    endfunction

    task automatic model_reset();
        m_flow   = 0;
        m_frames = 0;
        for (int i = 0; i < 16; i++) m_seq[i] = 0;
    endtask

    task automatic cfg(input int len, input int ifg, input int burst);
        frame_len   = 11'(len);
        ifg_cycles  = 8'(ifg);
        burst_count = 16'(burst);
        m_dst       = 48'({$urandom(), $urandom()});
        m_src       = 48'({$urandom(), $urandom()});
        dst_mac     = m_dst;
        src_mac     = m_src;
    endtask

    task automatic do_reset();
        s_aresetn = 1'b0;
        enable    = 1'b0;
        repeat (2) @(negedge clk156);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tlast",  64'(m_axis_tlast),  64'(0));
        chk("rst_tkeep",  64'(m_axis_tkeep),  64'(0));
        chk("rst_tdata",  m_axis_tdata,       64'(0));
        chk("rst_busy",   64'(busy),          64'(0));
        chk("rst_done",   64'(done),          64'(0));
        chk("rst_frames", 64'(frames_sent),   64'(0));
        chk("rst_tuser",  64'(m_axis_tuser),  64'(0));
        s_aresetn = 1'b1;
        model_reset();
        @(negedge clk156);
    endtask

    // Receives one frame starting at the current negedge; returns at the
    // negedge after the last beat is accepted (or after an injected reset).
    task automatic run_frame(input int len, input bit rnd_ready, input int drop_en_at,
                             input int rst_at, output int first_cyc, output int last_cyc);
        int          beats   = (len + 7) / 8;
        int          b       = 0;
        int          flow    = m_flow;
        logic [31:0] seq     = m_seq[m_flow];
        bit          started = 0;
        bit          fin     = 0;
        bit          aborted = 0;
        bit          stalled = 0;
        logic [63:0] prev    = '0;
        logic [63:0] ts_exp  = '0;
        logic [63:0] ed;
        logic [7:0]  ek;
        int          rem;
        first_cyc = 0;
        last_cyc  = 0;
        for (int budget = 0; budget < 4000 && !fin; budget++) begin
            m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid) begin
                if (!started) begin
                    started   = 1;
                    ts_exp    = tb_ts - 1;
                    first_cyc = cyc;
                end
                if (stalled) chk("stall_hold", m_axis_tdata, prev);
                ed = '0;
                for (int k = 0; k < 8; k++)
                    if (8*b + k < len) ed[8*k +: 8] = exp_byte(8*b + k, flow, seq, ts_exp);
                rem = len - 8*b;
                ek  = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
                chk("tdata", m_axis_tdata, ed);
                chk("tkeep", 64'(m_axis_tkeep), 64'(ek));
                chk("tlast", 64'(m_axis_tlast), 64'(b == beats - 1));
                chk("busy_send", 64'(busy), 64'(1));
                if (drop_en_at == b) enable = 1'b0;
                stalled = !m_axis_tready;
                prev    = m_axis_tdata;
                if (rst_at == b) begin
                    s_aresetn = 1'b0;
                    aborted   = 1;
                    fin       = 1;
                end else if (m_axis_tready) begin
                    if (b == beats - 1) begin
                        fin      = 1;
                        last_cyc = cyc;
                    end
                    b++;
                end
            end else if (started) begin
                chk("tvalid_mid", 64'(m_axis_tvalid), 64'(1));
            end
            @(negedge clk156);
        end
        if (!fin) chk("frame_timeout", 64'(0), 64'(1));
        else if (!aborted) begin
            m_seq[flow] = m_seq[flow] + 1;
            m_flow      = (m_flow + 1) % FLOWS;
            m_frames    = m_frames + 1;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && !done; i++) @(negedge clk156);
        chk("done",        64'(done),        64'(1));
        chk("done_busy",   64'(busy),        64'(0));
        chk("done_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("frames_sent", 64'(frames_sent), 64'(m_frames));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l, len;
        int firsts[4];
        int lasts[4];
        s_aresetn     = 1'b0;
        enable        = 1'b0;
        m_axis_tready = 1'b0;
        cfg(60, 0, 0);
        repeat (2) @(negedge clk156);
        do_reset();

        // Single 60-byte frame from a one-cycle enable pulse
        cfg(60, 0, 1);
        enable = 1'b1;
        @(negedge clk156);
        chk("first_beat_latency", 64'(m_axis_tvalid), 64'(1));
        enable = 1'b0;
        run_frame(60, 0, -1, -1, f, l);
        wait_done();
        @(negedge clk156);
        chk("done_release", 64'(done), 64'(0));

        // Six 64-byte frames across four flows
        do_reset();
        cfg(64, 2, 6);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) run_frame(64, 0, -1, -1, f, l);
        wait_done();
        chk("flow_after_burst", 64'(m_flow), 64'(2));
        repeat (3) @(negedge clk156);
        chk("done_hold", 64'(done), 64'(1));
        enable = 1'b0;
        repeat (2) @(negedge clk156);
        chk("done_cleared", 64'(done), 64'(0));

        // 100-byte frames under random backpressure
        cfg(100, 3, 2);
        enable = 1'b1;
        for (int i = 0; i < 2; i++) run_frame(100, 1, -1, -1, f, l);
        wait_done();
        enable = 1'b0;
        repeat (2) @(negedge clk156);

        // Continuous mode with a 5-cycle gap, then enable drop mid-frame
        len = 60 + int'($urandom_range(0, 140));
        cfg(len, 5, 0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++)
            run_frame(len, 0, (i == 3) ? 1 : -1, -1, firsts[i], lasts[i]);
        for (int i = 1; i < 4; i++) begin
            chk("ifg_idle_cycles", 64'(firsts[i] - lasts[i-1] - 1), 64'(5));
            chk("frame_period", 64'(firsts[i] - firsts[i-1]), 64'((len + 7) / 8 + 5));
        end
        for (int i = 0; i < 5; i++) begin
            chk("gap_busy",   64'(busy),          64'(1));
            chk("gap_tvalid", 64'(m_axis_tvalid), 64'(0));
            @(negedge clk156);
        end
        chk("stop_busy", 64'(busy), 64'(0));
        chk("stop_done", 64'(done), 64'(0));
        chk("stop_frames", 64'(frames_sent), 64'(m_frames));

        // Length clamping at both ends
        cfg(20, 0, 1);
        enable = 1'b1;
        run_frame(clampl(20), 0, -1, -1, f, l);
        wait_done();
        enable = 1'b0;
        repeat (2) @(negedge clk156);
        cfg(2000, 1, 1);
        enable = 1'b1;
        run_frame(clampl(2000), 0, -1, -1, f, l);
        chk("max_len_beats", 64'(l - f + 1), 64'(190));
        wait_done();
        enable = 1'b0;
        repeat (2) @(negedge clk156);

        // Reset in the middle of a frame
        cfg(128, 0, 0);
        enable = 1'b1;
        run_frame(128, 0, -1, 3, f, l);
        chk("abort_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("abort_frames", 64'(frames_sent),   64'(0));
        chk("abort_busy",   64'(busy),          64'(0));
        s_aresetn = 1'b1;
        model_reset();
        run_frame(128, 0, 0, -1, f, l);
        @(negedge clk156);
        chk("post_abort_frames", 64'(frames_sent), 64'(1));
        chk("post_abort_busy",   64'(busy),        64'(0));

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            int burst;
            len   = int'($urandom_range(0, 2047));
            burst = int'($urandom_range(1, 3));
            cfg(len, int'($urandom_range(0, 3)), burst);
            enable = 1'b1;
            for (int i = 0; i < burst; i++) run_frame(clampl(len), 1, -1, -1, f, l);
            wait_done();
            enable = 1'b0;
            repeat (2) @(negedge clk156);
            chk("rand_done_clear", 64'(done), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
